cd_sdpram_fifo: RTL

Synchronous first-word-fall-through FIFO controller that drives an external cd_sdpram instance of the same A_WIDTH/D_WIDTH and consumes its registered read data. It sits between a producer (e.g. RX byte path) and a consumer (e.g. frame assembler), both using valid/ready handshakes. It owns the write and read pointers, occupancy and a 2-entry output buffer that hides the RAM's 1-cycle read latency. The output buffer sustains 1 word/cycle.

---
 rtl/cd_sdpram_fifo.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/cd_sdpram_fifo.sv
// cd_sdpram_fifo
// First-word-fall-through FIFO controller for an external cd_sdpram of the
// same A_WIDTH/D_WIDTH. It owns the write/read pointers and the RAM word
// count. A 2-entry output buffer hides the RAM's 1-cycle read latency, so
// the buffer can deliver 1 word per cycle.
//
// Ports
//   clk       : clock, all logic on the rising edge
//   reset_n   : asynchronous active-low reset
//   clr       : synchronous flush, active high
//   in_data   : write word from the producer
//   in_valid  : the producer has a word
//   in_ready  : the FIFO accepts the word this cycle
//   out_data  : head word (buffer entry b0)
//   out_valid : out_data is valid
//   out_ready : the consumer takes the head this cycle
//   count     : committed words held in the RAM (the output buffer is not
//               included); saturates at 2**A_WIDTH
//   ram_cen   : RAM chip enable, active low
//   ram_ra    : RAM read address
//   ram_rd    : RAM read data, valid the cycle after a read is issued
//   ram_wa    : RAM write address
//   ram_wd    : RAM write data (equal to in_data)
//   ram_wen   : RAM write enable, active low
//
// SP_COMPAT=1 is for a RAM built single-port only. In that mode a read is
// never issued in a write cycle, so a write always wins.
module cd_sdpram_fifo #(
  parameter int A_WIDTH   = 8,
  parameter int D_WIDTH   = 8,
  parameter int SP_COMPAT = 0
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               clr,
  input  logic [D_WIDTH-1:0] in_data,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [D_WIDTH-1:0] out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [A_WIDTH:0]   count,
  output logic               ram_cen,
  output logic [A_WIDTH-1:0] ram_ra,
  input  logic [D_WIDTH-1:0] ram_rd,
  output logic [A_WIDTH-1:0] ram_wa,
  output logic [D_WIDTH-1:0] ram_wd,
  output logic               ram_wen
);

  localparam logic [A_WIDTH:0] FULL_CNT = (A_WIDTH+1)'(2**A_WIDTH);

  logic [A_WIDTH-1:0] wptr_r;
  logic [A_WIDTH-1:0] rptr_r;
  logic [A_WIDTH:0]   ram_cnt_r;
  logic               rd_pend_r;
  logic [D_WIDTH-1:0] b0_r;
  logic [D_WIDTH-1:0] b1_r;
  logic [1:0]         occ_r;

  logic               push_s;
  logic               pop_s;
  logic               iss_s;
  logic               sp_block_s;
  logic [2:0]         room_s;
  logic [A_WIDTH:0]   ram_cnt_nxt_s;
  logic [D_WIDTH-1:0] b0_nxt_s;
  logic [D_WIDTH-1:0] b1_nxt_s;
  logic [1:0]         occ_nxt_s;

  assign in_ready = (ram_cnt_r != FULL_CNT) && !clr;
  assign push_s   = in_valid && in_ready;
  assign pop_s    = out_valid && out_ready;

  // Count the slots already claimed after this cycle's pop: words held in
  // the buffer plus a read already in flight. Keep at most 2 claimed slots.
  assign room_s     = {1'b0, occ_r} + {2'b00, rd_pend_r} - {2'b00, pop_s};
  assign sp_block_s = (SP_COMPAT != 0) ? push_s : 1'b0;
  assign iss_s      = (ram_cnt_r != '0) && (room_s < 3'd2) && !clr && !sp_block_s;

  assign ram_cnt_nxt_s = ram_cnt_r + {{A_WIDTH{1'b0}}, push_s}
                                   - {{A_WIDTH{1'b0}}, iss_s};

  assign ram_cen = !(push_s || iss_s);
  assign ram_wen = !push_s;
  assign ram_wa  = wptr_r;
  assign ram_ra  = rptr_r;
  assign ram_wd  = in_data;

  assign out_valid = (occ_r != 2'd0);
  assign out_data  = b0_r;
  assign count     = ram_cnt_r;

  // Next output-buffer state. The pop shift is applied first. The returning
  // read word then goes into the lowest slot that is still free.
  always_comb begin
    b0_nxt_s  = b0_r;
    b1_nxt_s  = b1_r;
    occ_nxt_s = occ_r;
    if (pop_s) begin
      b0_nxt_s  = b1_r;
      occ_nxt_s = occ_r - 2'd1;
    end else begin
      occ_nxt_s = occ_r;
    end
    if (rd_pend_r) begin
      if (occ_nxt_s == 2'd0) begin
        b0_nxt_s = ram_rd;
      end else begin
        b1_nxt_s = ram_rd;
      end
      occ_nxt_s = occ_nxt_s + 2'd1;
    end else begin
      b1_nxt_s = b1_nxt_s;
    end
  end

  // Pointer, count, read-in-flight and buffer registers. A flush discards
  // all of this state, including a read that is still in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr_r    <= '0;
      rptr_r    <= '0;
      ram_cnt_r <= '0;
      rd_pend_r <= 1'b0;
      b0_r      <= '0;
      b1_r      <= '0;
      occ_r     <= 2'd0;
    end else if (clr) begin
      wptr_r    <= '0;
      rptr_r    <= '0;
      ram_cnt_r <= '0;
      rd_pend_r <= 1'b0;
      b0_r      <= '0;
      b1_r      <= '0;
      occ_r     <= 2'd0;
    end else begin
      if (push_s) begin
        wptr_r <= wptr_r + {{(A_WIDTH-1){1'b0}}, 1'b1};
      end
      if (iss_s) begin
        rptr_r <= rptr_r + {{(A_WIDTH-1){1'b0}}, 1'b1};
      end
      ram_cnt_r <= ram_cnt_nxt_s;
      rd_pend_r <= iss_s;
      b0_r      <= b0_nxt_s;
      b1_r      <= b1_nxt_s;
      occ_r     <= occ_nxt_s;
    end
  end

endmodule
